// File: rtl/spatz_mem_responder_pkg.sv
// Shared types for the Spatz VLSU memory port and its memory-side responder.
// The optional write-acknowledge mode is selected with SPATZ_MEM_RSP_WRITE_ACK_EN.
package spatz_mem_responder_pkg;

   localparam int unsigned ELEN             = 32;
   localparam int unsigned ELENB            = ELEN / 8;
   localparam int unsigned NRVREG           = 32;
   localparam int unsigned AddrWidth        = 32;
   localparam int unsigned IdWidth          = $clog2(NRVREG) + 1;
   localparam int unsigned RspIdWidth       = $clog2(NRVREG);
   localparam int unsigned MemRspMaxLatency = 4;

   typedef enum logic [1:0] {
      MEM_BYTE,
      MEM_HALF,
      MEM_WORD,
      MEM_DOUBLE
   } mem_size_e;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [AddrWidth-1:0] addr;
      logic [1:0]           mode;
      mem_size_e            size;
      logic                 we;
      logic [ELENB-1:0]     strb;
      logic [ELEN-1:0]      wdata;
      logic                 last;
      logic                 spec;
   } spatz_mem_req_t;

   typedef struct packed {
      logic [RspIdWidth-1:0] id;
      logic [ELEN-1:0]       rdata;
      logic                  err;
   } spatz_mem_resp_t;

   function automatic logic is_misaligned(input logic [AddrWidth-1:0] addr, input mem_size_e size);
      logic mis;
      case (size)
         MEM_BYTE: mis = 1'b0;
         MEM_HALF: mis = addr[0];
         MEM_WORD: mis = |addr[1:0];
         default:  mis = |addr[2:0];
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/spatz_mem_rsp_fifo.sv
// Fall-through response FIFO: an entry pushed into an empty FIFO is visible on data_o
// in the same cycle, and a simultaneous push/pop on an empty FIFO bypasses storage.
module spatz_mem_rsp_fifo #(
   parameter int unsigned Depth = 4,
   parameter type         T     = logic
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  T                           data_i,
   input  logic                       pop_i,
   output T                           data_o,
   output logic                       valid_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(Depth+1)-1:0] usage_o
);

   localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned UsageW = $clog2(Depth + 1);

   T                  mem_q [Depth];
   logic [PtrW-1:0]   wptr_q, wptr_d;
   logic [PtrW-1:0]   rptr_q, rptr_d;
   logic [UsageW-1:0] usage_q, usage_d;
   logic              do_write, do_read;

   assign empty_o = (usage_q == '0);
   assign full_o  = (usage_q == UsageW'(Depth));
   assign usage_o = usage_q;
   assign valid_o = !empty_o || push_i;
   assign data_o  = empty_o ? data_i : mem_q[rptr_q];

   assign do_write = push_i && !(empty_o && pop_i);
   assign do_read  = pop_i && !empty_o;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      usage_d = usage_q + UsageW'(do_write) - UsageW'(do_read);
      if (do_write) wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
      if (do_read)  rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         usage_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         usage_q <= usage_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_write) mem_q[wptr_q] <= data_i;
   end

   // Upstream credit accounting guarantees a free slot for every push.
   assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o && !pop_i));

endmodule

// File: rtl/spatz_mem_responder.sv
// Memory-side endpoint of the Spatz VLSU port: scratch memory, fixed-latency pipeline,
// credit-based backpressure. Define SPATZ_MEM_RSP_WRITE_ACK_EN to acknowledge writes.
module spatz_mem_responder
   import spatz_mem_responder_pkg::*;
#(
   parameter int unsigned NumWords     = 1024,
   parameter int unsigned Latency      = 2,
   parameter int unsigned RspFifoDepth = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  spatz_mem_req_t  mem_req_i,
   input  logic            mem_req_valid_i,
   output logic            mem_req_ready_o,
   output spatz_mem_resp_t mem_rsp_o,
   output logic            mem_rsp_valid_o,
   input  logic            mem_rsp_ready_i,
   output logic            idle_o
);

   localparam int unsigned IdxW  = $clog2(NumWords);
   localparam int unsigned OffW  = $clog2(ELENB);
   localparam int unsigned CredW = $clog2(RspFifoDepth + 1);
   localparam logic [AddrWidth-1:0] MemBytes = AddrWidth'(NumWords * ELENB);

   logic [ELEN-1:0]  mem_q [NumWords];
   logic [IdxW-1:0]  word_idx;
   logic             req_err, produces_rsp, req_fire, rsp_fire;
   spatz_mem_resp_t  rsp_new;

   logic [Latency-1:0] pipe_valid_q;
   spatz_mem_resp_t    pipe_data_q [Latency];
   logic [CredW-1:0]   credits_q, credits_d;

   logic                            fifo_full, fifo_empty;
   logic [$clog2(RspFifoDepth+1)-1:0] fifo_usage;
   logic                            unused_sink;

   assign word_idx = mem_req_i.addr[OffW +: IdxW];
   assign req_err  = (mem_req_i.addr >= MemBytes)
                  || is_misaligned(mem_req_i.addr, mem_req_i.size)
                  || ((mem_req_i.size == MEM_DOUBLE) && (ELEN < 64))
                  || (mem_req_i.mode != '0);

`ifdef SPATZ_MEM_RSP_WRITE_ACK_EN
   assign produces_rsp = 1'b1;
`else
   assign produces_rsp = !mem_req_i.we;
`endif

   // Both ports fire on valid && ready in the same cycle; a held response keeps mem_rsp_o stable.
   assign mem_req_ready_o = (credits_q != '0) || !produces_rsp;
   assign req_fire        = mem_req_valid_i && mem_req_ready_o;
   assign rsp_fire        = mem_rsp_valid_o && mem_rsp_ready_i;

   always_ff @(posedge clk_i) begin
      if (req_fire && mem_req_i.we && !req_err) begin
         for (int b = 0; b < int'(ELENB); b++) begin
            if (mem_req_i.strb[b]) mem_q[word_idx][b*8 +: 8] <= mem_req_i.wdata[b*8 +: 8];
         end
      end
   end

   always_comb begin
      rsp_new       = '0;
      rsp_new.id    = mem_req_i.id[RspIdWidth-1:0];
      rsp_new.err   = req_err;
      rsp_new.rdata = (mem_req_i.we || req_err) ? '0 : mem_q[word_idx];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pipe_valid_q <= '0;
         for (int i = 0; i < int'(Latency); i++) pipe_data_q[i] <= '0;
      end else begin
         pipe_valid_q[0] <= req_fire && produces_rsp;
         if (req_fire && produces_rsp) pipe_data_q[0] <= rsp_new;
         for (int i = 1; i < int'(Latency); i++) begin
            pipe_valid_q[i] <= pipe_valid_q[i-1];
            pipe_data_q[i]  <= pipe_data_q[i-1];
         end
      end
   end

   spatz_mem_rsp_fifo #(
      .Depth (RspFifoDepth),
      .T     (spatz_mem_resp_t)
   ) i_rsp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (pipe_valid_q[Latency-1]),
      .data_i  (pipe_data_q[Latency-1]),
      .pop_i   (rsp_fire),
      .data_o  (mem_rsp_o),
      .valid_o (mem_rsp_valid_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .usage_o (fifo_usage)
   );

   assign credits_d = credits_q - CredW'(req_fire && produces_rsp) + CredW'(rsp_fire);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) credits_q <= CredW'(RspFifoDepth);
      else       credits_q <= credits_d;
   end

   assign idle_o = !(|pipe_valid_q) && fifo_empty;

   assign unused_sink = ^{mem_req_i.last, mem_req_i.spec, mem_req_i.id[IdWidth-1], fifo_full, fifo_usage};

`ifndef SPATZ_MEM_RSP_WRITE_ACK_EN
   // Erroring writes vanish silently in this mode; flag them.
   assert property (@(posedge clk_i) disable iff (rst_i) !(req_fire && mem_req_i.we && req_err));
`endif

endmodule

// File: tb/tb_spatz_mem_responder.sv
// Bench for spatz_mem_responder: scoreboard of expected responses checked in order.
// Honors SPATZ_MEM_RSP_WRITE_ACK_EN for write-acknowledge expectations.
module tb_spatz_mem_responder;
   import spatz_mem_responder_pkg::*;

   localparam int LATENCY   = 2;
   localparam int NUM_WORDS = 1024;
   localparam int DEPTH     = 4;
   localparam int RSP_W     = $bits(spatz_mem_resp_t);
`ifdef SPATZ_MEM_RSP_WRITE_ACK_EN
   localparam bit WR_ACK = 1'b1;
`else
   localparam bit WR_ACK = 1'b0;
`endif

   logic            clk, rst;
   spatz_mem_req_t  mem_req;
   logic            mem_req_valid, mem_req_ready;
   spatz_mem_resp_t mem_rsp;
   logic            mem_rsp_valid, mem_rsp_ready, idle;

   spatz_mem_responder #(
      .NumWords     (NUM_WORDS),
      .Latency      (LATENCY),
      .RspFifoDepth (DEPTH)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .mem_req_i       (mem_req),
      .mem_req_valid_i (mem_req_valid),
      .mem_req_ready_o (mem_req_ready),
      .mem_rsp_o       (mem_rsp),
      .mem_rsp_valid_o (mem_rsp_valid),
      .mem_rsp_ready_i (mem_rsp_ready),
      .idle_o          (idle)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // scoreboard
   logic [RSP_W-1:0] exp_q[$];
   int               rsp_cyc_q[$];
   logic [31:0]      model_mem [NUM_WORDS];
   int               checks = 0;
   int               failures = 0;
   logic             acc_ok;
   int               acc_cyc;

   always @(negedge clk) begin
      if (!rst && mem_rsp_valid && mem_rsp_ready) begin
         rsp_cyc_q.push_back(cyc);
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_rsp: got %h, expected none", mem_rsp);
         end else begin
            logic [RSP_W-1:0] e;
            e = exp_q.pop_front();
            if (mem_rsp !== e) begin
               failures++;
               $display("FAIL rsp_data: got %h, expected %h", mem_rsp, e);
            end
         end
      end
   end

   // drivers
   task automatic send_req(input logic we, input logic [31:0] addr, input mem_size_e size,
                           input logic [3:0] strb, input logic [31:0] wdata, input logic [5:0] id,
                           input logic [1:0] mode, input logic exp_err, input int max_wait);
      spatz_mem_resp_t e;
      logic [9:0]      idx;
      mem_req       = '0;
      mem_req.we    = we;
      mem_req.addr  = addr;
      mem_req.size  = size;
      mem_req.strb  = strb;
      mem_req.wdata = wdata;
      mem_req.id    = id;
      mem_req.mode  = mode;
      mem_req.last  = 1'($urandom_range(0, 1));
      mem_req.spec  = 1'($urandom_range(0, 1));
      mem_req_valid = 1'b1;
      acc_ok = 1'b0;
      idx = addr[2 +: 10];
      for (int i = 0; i < max_wait; i++) begin
         @(negedge clk);
         if (mem_req_ready) begin
            acc_ok  = 1'b1;
            acc_cyc = cyc;
            if (!we || WR_ACK) begin
               e       = '0;
               e.id    = id[4:0];
               e.err   = exp_err;
               e.rdata = (we || exp_err) ? 32'h0 : model_mem[idx];
               exp_q.push_back(e);
            end
            if (we && !exp_err) begin
               for (int b = 0; b < 4; b++)
                  if (strb[b]) model_mem[idx][b*8 +: 8] = wdata[b*8 +: 8];
            end
            break;
         end
      end
      @(posedge clk);
      #1;
      mem_req_valid = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      send_req(1'b1, addr, MEM_WORD, strb, data, 6'd0, 2'd0, 1'b0, 50);
   endtask

   task automatic rd(input logic [31:0] addr, input logic [5:0] id);
      send_req(1'b0, addr, MEM_WORD, 4'h0, 32'h0, id, 2'd0, 1'b0, 50);
   endtask

   task automatic wait_drain(input string name);
      logic done;
      done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && idle) begin
            done = 1'b1;
            break;
         end
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL %s_drain: pending=%0d idle=%b, expected pending=0 idle=1", name, exp_q.size(), idle);
      end
      @(posedge clk);
      #1;
   endtask

   // tests
   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks += 4;
      if (mem_req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b, expected 1", mem_req_ready); end
      if (mem_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b, expected 0", mem_rsp_valid); end
      if (mem_rsp !== '0) begin failures++; $display("FAIL reset_rsp: got %h, expected 0", mem_rsp); end
      if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle: got %b, expected 1", idle); end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_write_read();
      mem_rsp_ready = 1'b1;
      rsp_cyc_q.delete();
      wr(32'h10, 32'hDEAD_BEEF, 4'hF);
      rd(32'h10, 6'd7);
      wait_drain("write_read");
      checks++;
      if (rsp_cyc_q.size() == 0 || rsp_cyc_q[$] - acc_cyc != LATENCY) begin
         failures++;
         $display("FAIL latency: got %0d, expected %0d", rsp_cyc_q.size() ? rsp_cyc_q[$] - acc_cyc : -1, LATENCY);
      end
      wr(32'h10, 32'h1234_5678, 4'h3);
      rd(32'h10, 6'h25);
      wait_drain("partial_strb");
   endtask

   task automatic test_credits();
      logic [RSP_W-1:0] held;
      mem_rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) wr(32'h40 + 32'(4 * i), $urandom, 4'hF);
      wait_drain("credit_prefill");
      mem_rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rd(32'h40 + 32'(4 * i), 6'(i + 1));
         checks++;
         if (acc_ok !== 1'b1) begin failures++; $display("FAIL credit_accept%0d: got %b, expected 1", i, acc_ok); end
      end
      mem_req.we = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_req_ready !== 1'b0) begin failures++; $display("FAIL credit_exhausted: ready=%b, expected 0", mem_req_ready); end
      rd(32'h50, 6'd5);
      send_req(1'b0, 32'h50, MEM_WORD, 4'h0, 32'h0, 6'd5, 2'd0, 1'b0, 4);
      checks++;
      if (acc_ok !== 1'b0) begin failures++; $display("FAIL credit_block: accepted=%b, expected 0", acc_ok); end
      // the rd above was also blocked; drop its bookkeeping effect (none pushed when not accepted)
      @(negedge clk);
      held = mem_rsp;
      @(negedge clk);
      checks++;
      if (mem_rsp_valid !== 1'b1 || mem_rsp !== held) begin
         failures++;
         $display("FAIL rsp_stable: valid=%b data=%h, expected valid=1 data=%h", mem_rsp_valid, mem_rsp, held);
      end
      @(posedge clk);
      #1;
      mem_rsp_ready = 1'b1;
      send_req(1'b0, 32'h50, MEM_WORD, 4'h0, 32'h0, 6'd5, 2'd0, 1'b0, 20);
      checks++;
      if (acc_ok !== 1'b1) begin failures++; $display("FAIL credit_resume5: accepted=%b, expected 1", acc_ok); end
      send_req(1'b0, 32'h54, MEM_WORD, 4'h0, 32'h0, 6'd6, 2'd0, 1'b0, 20);
      checks++;
      if (acc_ok !== 1'b1) begin failures++; $display("FAIL credit_resume6: accepted=%b, expected 1", acc_ok); end
      wait_drain("credits");
   endtask

   task automatic test_errors();
      mem_rsp_ready = 1'b1;
      wr(32'h0, 32'hA5A5_1234, 4'hF);
      send_req(1'b0, 32'h2, MEM_WORD, 4'h0, 32'h0, 6'd11, 2'd0, 1'b1, 50);
      send_req(1'b0, 32'(NUM_WORDS * 4), MEM_WORD, 4'h0, 32'h0, 6'd12, 2'd0, 1'b1, 50);
      send_req(1'b0, 32'h4, MEM_DOUBLE, 4'h0, 32'h0, 6'd13, 2'd0, 1'b1, 50);
      send_req(1'b0, 32'h8, MEM_WORD, 4'h0, 32'h0, 6'd14, 2'd1, 1'b1, 50);
      send_req(1'b0, 32'h1, MEM_HALF, 4'h0, 32'h0, 6'd15, 2'd0, 1'b1, 50);
      send_req(1'b0, 32'h3, MEM_BYTE, 4'h0, 32'h0, 6'd16, 2'd0, 1'b0, 50);
      send_req(1'b0, 32'h2, MEM_HALF, 4'h0, 32'h0, 6'd17, 2'd0, 1'b0, 50);
      rd(32'h0, 6'd18);
      wait_drain("errors");
   endtask

   task automatic test_back_to_back();
      int first_acc;
      mem_rsp_ready = 1'b1;
      rsp_cyc_q.delete();
      for (int i = 0; i < 8; i++) begin
         rd(32'h40 + 32'(4 * $urandom_range(0, 5)), 6'($urandom_range(0, 63)));
         if (i == 0) first_acc = acc_cyc;
      end
      checks++;
      if (acc_cyc - first_acc != 7) begin failures++; $display("FAIL b2b_accept: span=%0d, expected 7", acc_cyc - first_acc); end
      wait_drain("back_to_back");
      checks++;
      if (rsp_cyc_q.size() != 8 || rsp_cyc_q[$] - rsp_cyc_q[0] != 7) begin
         failures++;
         $display("FAIL b2b_rsp: count=%0d, expected 8 responses in 8 cycles", rsp_cyc_q.size());
      end
   endtask

   task automatic test_reset_mid();
      mem_rsp_ready = 1'b1;
      wr(32'h80, 32'h1111_2222, 4'hF);
      wait_drain("reset_prefill");
      mem_rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) rd(32'h80, 6'(20 + i));
      rst = 1'b1;
      #1;
      checks += 3;
      if (mem_rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid: got %b, expected 0", mem_rsp_valid); end
      if (idle !== 1'b1) begin failures++; $display("FAIL mid_reset_idle: got %b, expected 1", idle); end
      if (mem_req_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready: got %b, expected 1", mem_req_ready); end
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rd(32'h80, 6'(30 + i));
         checks++;
         if (acc_ok !== 1'b1) begin failures++; $display("FAIL mid_reset_credit%0d: got %b, expected 1", i, acc_ok); end
      end
      mem_rsp_ready = 1'b1;
      wait_drain("reset_mid");
   endtask

   task automatic test_write_at_zero_credits();
      mem_rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) rd(32'h40 + 32'(4 * i), 6'(40 + i));
      send_req(1'b1, 32'h90, MEM_WORD, 4'hF, 32'hCAFE_F00D, 6'd44, 2'd0, 1'b0, 3);
      checks++;
      if (acc_ok !== !WR_ACK) begin failures++; $display("FAIL zero_credit_write: accepted=%b, expected %b", acc_ok, !WR_ACK); end
      mem_rsp_ready = 1'b1;
      if (WR_ACK) send_req(1'b1, 32'h90, MEM_WORD, 4'hF, 32'hCAFE_F00D, 6'd44, 2'd0, 1'b0, 30);
      rd(32'h90, 6'd45);
      wait_drain("zero_credit");
   endtask

   initial begin
      rst           = 1'b1;
      mem_req       = '0;
      mem_req_valid = 1'b0;
      mem_rsp_ready = 1'b0;
      test_reset();
      test_write_read();
      test_credits();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      test_write_at_zero_credits();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
